sram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the shared latency SRAM (`SP_SRAM_LATENCY`-style: active-low `CSN`, `WEN`, byte enables, `READY` pulse, registered `DOUT`).
- Grants one of two requesters at a time: instruction fetch (read-only) and data load/store.
- Holds the SRAM request stable until `READY`, then returns a one-cycle acknowledge with read data.
- Applies round-robin fairness and a watchdog timeout.
- Sits between the core's fetch/LSU ports and the single unified memory.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/sram_arbiter_if.sv | 62 ++++++
 rtl/sram_arbiter_rr_arb2.sv | 29 ++
 rtl/sram_arbiter.sv | 149 ++++++++++++++
 tb/tb_sram_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the SRAM arbiter: FSM state encoding, requester port
// IDs and the default SRAM latency / watchdog timeout values.
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Port IDs double as bit positions in the two-bit request/grant vectors.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam int DEF_AWIDTH      = 12;
  localparam int DEF_MEM_LATENCY = 2;
  localparam int DEF_TIMEOUT     = 15;
  localparam int BUSY_CNT_W      = 5;

endpackage

// File: rtl/sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces around sram_arbiter.
//
// core_bus_if : core-side fetch and load/store request ports.
//   master = core (drives I_REQ/I_ADDR, D_REQ/D_WE/D_BE/D_ADDR/D_WDATA)
//   slave  = arbiter (drives I_ACK/I_RDATA, D_ACK/D_RDATA, ERR)
//
// sram_bus_if : single-port latency SRAM.
//   master = arbiter (drives M_CSN/M_WEN/M_BE/M_ADDR/M_DI/M_LATENCY)
//   slave  = SRAM (drives M_DOUT/M_READY)
// -----------------------------------------------------------------------------
interface core_bus_if #(
  parameter int AWIDTH = 12
);
  logic              I_REQ;
  logic [AWIDTH-1:0] I_ADDR;
  logic              I_ACK;
  logic [31:0]       I_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [3:0]        D_BE;
  logic [AWIDTH-1:0] D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_ACK;
  logic [31:0]       D_RDATA;

  logic              ERR;

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    input  I_ACK, I_RDATA, D_ACK, D_RDATA, ERR
  );

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA,
    output I_ACK, I_RDATA, D_ACK, D_RDATA, ERR
  );
endinterface

interface sram_bus_if #(
  parameter int AWIDTH = 12
);
  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [2:0]        M_LATENCY;
  logic [31:0]       M_DOUT;
  logic              M_READY;

  modport master (
    output M_CSN, M_WEN, M_BE, M_ADDR, M_DI, M_LATENCY,
    input  M_DOUT, M_READY
  );

  modport slave (
    input  M_CSN, M_WEN, M_BE, M_ADDR, M_DI, M_LATENCY,
    output M_DOUT, M_READY
  );
endinterface

// File: rtl/sram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin picker, purely combinational.
//   req[1:0]   in  : request vector, indexed by port ID (bit0 = I, bit1 = D)
//   last       in  : port granted most recently (held by the parent)
//   grant[1:0] out : one-hot grant, or zero when nothing is requested
// On a tie the port that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves grant
    // unassigned; otherwise synthesis infers a latch.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == PORT_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates the core's instruction-fetch and load/store ports onto a single
// latency SRAM. One access at a time: the winner's request is captured in
// IDLE, held on the SRAM during BUSY until M_READY (or the watchdog expires),
// and completed in RESP with a one-cycle ACK carrying M_DOUT.
//
// Ports:
//   CLK  in : clock, rising edge
//   RST  in : synchronous, active-high reset
//   core    : core_bus_if.slave  - I_REQ/I_ADDR/I_ACK/I_RDATA,
//             D_REQ/D_WE/D_BE/D_ADDR/D_WDATA/D_ACK/D_RDATA, ERR
//   mem     : sram_bus_if.master - M_CSN/M_WEN/M_BE/M_ADDR/M_DI/M_LATENCY,
//             M_DOUT/M_READY
// -----------------------------------------------------------------------------
module sram_arbiter
  import mem_pkg::*;
#(
  parameter int AWIDTH      = DEF_AWIDTH,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY,  // 1..7
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input logic        CLK,
  input logic        RST,
  core_bus_if.slave  core,
  sram_bus_if.master mem
);

  // The counter reads 0 in the first BUSY cycle, so TIMEOUT-1 marks the last
  // BUSY cycle that may still wait for M_READY.
  localparam logic [BUSY_CNT_W-1:0] BUSY_LAST = BUSY_CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  port_t                 last_q, owner_q, winner;
  logic                  err_q;
  logic [BUSY_CNT_W-1:0] busy_cnt_q;
  logic                  timeout_hit;
  logic [1:0]            req, grant;

  logic                  m_csn;
  logic                  m_wen_q;
  logic [3:0]            m_be_q;
  logic [AWIDTH-1:0]     m_addr_q;
  logic [31:0]           m_di_q;
  logic                  i_ack, d_ack, err;

  assign req = {core.D_REQ, core.I_REQ};

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .grant (grant)
  );

  assign winner      = grant[PORT_D] ? PORT_D : PORT_I;
  assign timeout_hit = (busy_cnt_q == BUSY_LAST);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values; reset is synchronous, checked inside the edge.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. M_READY wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|req)                         state_d = ST_BUSY;
      ST_BUSY: if (mem.M_READY || timeout_hit)   state_d = ST_RESP;
      ST_RESP:                                   state_d = ST_IDLE;
      default:                                   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state. Chip select is released in RESP so the SRAM
  // output register holds M_DOUT through the ACK cycle.
  always_comb begin
    m_csn = 1'b1;
    i_ack = 1'b0;
    d_ack = 1'b0;
    err   = 1'b0;
    case (state_q)
      ST_BUSY: m_csn = 1'b0;
      ST_RESP: begin
        i_ack = (owner_q == PORT_I);
        d_ack = (owner_q == PORT_D);
        err   = err_q;
      end
      default: ;
    endcase
  end

  // Grant capture, round-robin history and watchdog. Requests are only looked
  // at in IDLE; later changes on the core ports do not reach the SRAM.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q     <= PORT_D;
      owner_q    <= PORT_I;
      err_q      <= 1'b0;
      busy_cnt_q <= '0;
      m_wen_q    <= 1'b1;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_di_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            last_q     <= winner;
            owner_q    <= winner;
            err_q      <= 1'b0;
            busy_cnt_q <= '0;
            if (winner == PORT_I) begin
              m_wen_q  <= 1'b1;
              m_be_q   <= '0;
              m_addr_q <= core.I_ADDR;
            end else begin
              m_wen_q  <= ~core.D_WE;
              m_be_q   <= core.D_BE;
              m_addr_q <= core.D_ADDR;
              m_di_q   <= core.D_WDATA;
            end
          end
        end
        ST_BUSY: begin
          busy_cnt_q <= busy_cnt_q + BUSY_CNT_W'(1);
          if (timeout_hit && !mem.M_READY) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.M_CSN     = m_csn;
  assign mem.M_WEN     = m_wen_q;
  assign mem.M_BE      = m_be_q;
  assign mem.M_ADDR    = m_addr_q;
  assign mem.M_DI      = m_di_q;
  assign mem.M_LATENCY = 3'(MEM_LATENCY);

  assign core.I_ACK    = i_ack;
  assign core.D_ACK    = d_ack;
  assign core.ERR      = err;
  assign core.I_RDATA  = mem.M_DOUT;
  assign core.D_RDATA  = mem.M_DOUT;

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Drives sram_arbiter against a small latency-SRAM stub whose latency can be
// changed between accesses, and checks the outputs every cycle against a
// transaction-level model (grant cycle, ACK cycle, expected memory contents),
// plus directed literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;
  import mem_pkg::*;

  localparam int AW  = 12;
  localparam int LAT = 2;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  core_bus_if #(.AWIDTH(AW)) core ();
  sram_bus_if #(.AWIDTH(AW)) mem ();

  sram_arbiter #(
    .AWIDTH      (AW),
    .MEM_LATENCY (LAT),
    .TIMEOUT     (TMO)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .core (core),
    .mem  (mem)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // SRAM stub: READY in the Lth consecutive cycle with CSN low, access done on
  // that edge, DOUT registered.
  // ---------------------------------------------------------------------------
  logic [2:0]  sram_lat   = 3'd2;
  logic        ready_mask = 1'b0;
  logic [2:0]  sram_cnt   = '0;
  logic [31:0] sram_dout  = '0;
  logic [31:0] sram_mem [4096] = '{default: '0};

  assign mem.M_DOUT  = sram_dout;
  assign mem.M_READY = !mem.M_CSN && !ready_mask && (sram_cnt == sram_lat - 3'd1);

  always @(posedge clk) begin
    if (mem.M_CSN) sram_cnt <= '0;
    else if (sram_cnt != 3'd7) sram_cnt <= sram_cnt + 3'd1;
    if (mem.M_READY) begin
      if (mem.M_WEN) sram_dout <= sram_mem[mem.M_ADDR];
      else begin
        for (int b = 0; b < 4; b++)
          if (mem.M_BE[b]) sram_mem[mem.M_ADDR][8*b +: 8] <= mem.M_DI[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction model: a grant in idle cycle g completes with ACK in cycle
  // g + L + 1 (or g + TIMEOUT + 1 when READY is withheld); the next idle cycle
  // follows the ACK. Reads must return the model's own memory image.
  // ---------------------------------------------------------------------------
  typedef struct {
    port_t       port;
    int          cyc;
    logic [31:0] data;
    logic        err;
  } ack_t;

  ack_t        ack_log[$];
  logic [31:0] exp_mem [4096] = '{default: '0};

  bit          m_started = 0;
  bit          m_active  = 0;
  port_t       m_last    = PORT_D;
  port_t       m_port    = PORT_I;
  int          m_gcyc    = 0;
  int          m_acyc    = 0;
  int          m_free    = 0;
  bit          m_err     = 0;
  bit          m_we      = 0;
  logic [3:0]  m_be      = '0;
  logic [AW-1:0] m_addr  = '0;
  logic [31:0] m_wdata   = '0;
  bit          e_busy, e_ack;
  logic [31:0] e_data;

  initial forever begin
    @(negedge clk);
    if (m_started) begin
      e_busy = m_active && (cyc > m_gcyc) && (cyc < m_acyc);
      e_ack  = m_active && (cyc == m_acyc);
      check("m_csn", mem.M_CSN, !e_busy);
      check("i_ack", core.I_ACK, e_ack && (m_port == PORT_I));
      check("d_ack", core.D_ACK, e_ack && (m_port == PORT_D));
      check("err",   core.ERR,   e_ack && m_err);
      if (e_busy) begin
        check("m_wen",  mem.M_WEN,  (m_port == PORT_I) ? 1'b1 : !m_we);
        check("m_be",   mem.M_BE,   (m_port == PORT_I) ? 4'h0 : m_be);
        check("m_addr", mem.M_ADDR, m_addr);
        if (m_port == PORT_D && m_we) check("m_di", mem.M_DI, m_wdata);
      end
      if (e_ack) begin
        e_data = (m_port == PORT_I) ? core.I_RDATA : core.D_RDATA;
        if (!m_err) begin
          if (m_port == PORT_D && m_we) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) exp_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
          end else begin
            check("rdata", e_data, exp_mem[m_addr]);
          end
        end
        ack_log.push_back('{m_port, cyc, e_data, core.ERR});
        m_active = 0;
        m_free   = cyc + 1;
      end
    end
    if (rst) begin
      m_started = 1;
      m_active  = 0;
      m_free    = cyc + 1;
      m_last    = PORT_D;
    end else if (m_started && !m_active && cyc >= m_free && (core.I_REQ || core.D_REQ)) begin
      if (core.I_REQ && core.D_REQ) m_port = (m_last == PORT_I) ? PORT_D : PORT_I;
      else                          m_port = core.I_REQ ? PORT_I : PORT_D;
      m_last   = m_port;
      m_active = 1;
      m_gcyc   = cyc;
      m_err    = ready_mask;
      m_acyc   = cyc + (ready_mask ? TMO : int'(sram_lat)) + 1;
      if (m_port == PORT_I) begin
        m_we = 0; m_be = '0; m_addr = core.I_ADDR;
      end else begin
        m_we = core.D_WE; m_be = core.D_BE; m_addr = core.D_ADDR; m_wdata = core.D_WDATA;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // One access from an idle cycle; returns ACK distance, data, ERR and the
  // number of cycles the SRAM was selected.
  // ---------------------------------------------------------------------------
  task automatic access(input port_t p, input logic we, input logic [3:0] be,
                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output int csn_low);
    int c0;
    bit done = 0;
    @(posedge clk); #1;
    c0 = cyc;
    if (p == PORT_I) begin
      core.I_REQ = 1'b1; core.I_ADDR = addr;
    end else begin
      core.D_REQ = 1'b1; core.D_WE = we; core.D_BE = be;
      core.D_ADDR = addr; core.D_WDATA = wdata;
    end
    lat = -1; rdata = '0; err = 1'b0; csn_low = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!mem.M_CSN) csn_low++;
      if ((p == PORT_I && core.I_ACK) || (p == PORT_D && core.D_ACK)) begin
        lat   = cyc - c0;
        rdata = (p == PORT_I) ? core.I_RDATA : core.D_RDATA;
        err   = core.ERR;
        done  = 1;
      end
    end
    check("access_done", done, 1);
    @(posedge clk); #1;
    core.I_REQ = 1'b0;
    core.D_REQ = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, cl, rel, n0, base;
    logic [31:0] rd;
    logic        er;

    // Contention scenario is armed while reset is still asserted.
    sram_lat    = 3'd1;
    core.I_REQ  = 1'b1; core.I_ADDR  = 12'h030;
    core.D_REQ  = 1'b1; core.D_WE    = 1'b1; core.D_BE = 4'hF;
    core.D_ADDR = 12'h030; core.D_WDATA = 32'h55AA55AA;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m_csn",  mem.M_CSN,  1);
    check("rst_m_wen",  mem.M_WEN,  1);
    check("rst_m_be",   mem.M_BE,   0);
    check("rst_m_addr", mem.M_ADDR, 0);
    check("rst_m_di",   mem.M_DI,   0);
    check("rst_i_ack",  core.I_ACK, 0);
    check("rst_d_ack",  core.D_ACK, 0);
    check("rst_err",    core.ERR,   0);
    check("m_latency",  mem.M_LATENCY, 3'd2);

    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 60 && ack_log.size() < 4; i++) @(posedge clk);
    #1;
    core.I_REQ = 1'b0; core.D_REQ = 1'b0;
    check("cont_count", ack_log.size(), 4);
    if (ack_log.size() >= 4) begin
      check("cont_port0", ack_log[0].port, PORT_I);
      check("cont_port1", ack_log[1].port, PORT_D);
      check("cont_port2", ack_log[2].port, PORT_I);
      check("cont_port3", ack_log[3].port, PORT_D);
      check("cont_first", ack_log[0].cyc - rel, 2);
      for (int k = 0; k < 3; k++)
        check($sformatf("cont_gap%0d", k), ack_log[k+1].cyc - ack_log[k].cyc, 3);
      check("cont_rd0", ack_log[0].data, 32'h0);
      check("cont_rd2", ack_log[2].data, 32'h55AA55AA);
    end

    // Fetch read and write/read with partial byte enables at latency 2.
    sram_lat = 3'd2;
    access(PORT_D, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF, lat, rd, er, cl);
    check("wr010_lat", lat, 3);
    access(PORT_D, 1'b1, 4'hF, 12'h020, 32'hFFFFFFFF, lat, rd, er, cl);
    check("wr020_err", er, 0);
    access(PORT_I, 1'b0, 4'h0, 12'h010, 32'h0, lat, rd, er, cl);
    check("fetch_lat", lat, 3);
    check("fetch_data", rd, 32'hDEADBEEF);
    check("fetch_csn_cycles", cl, 2);
    check("fetch_err", er, 0);
    access(PORT_D, 1'b1, 4'b0011, 12'h020, 32'h1234ABCD, lat, rd, er, cl);
    check("wr_be_lat", lat, 3);
    access(PORT_D, 1'b0, 4'h0, 12'h020, 32'h0, lat, rd, er, cl);
    check("rd_be_data", rd, 32'hFFFFABCD);
    check("rd_be_lat", lat, 3);

    // Latency sweep.
    for (int l = 1; l <= 7; l++) begin
      sram_lat = 3'(l);
      access(PORT_I, 1'b0, 4'h0, 12'h010, 32'h0, lat, rd, er, cl);
      check($sformatf("sweep_lat_%0d", l), lat, l + 1);
      check($sformatf("sweep_data_%0d", l), rd, 32'hDEADBEEF);
      check($sformatf("sweep_err_%0d", l), er, 0);
    end

    // Watchdog timeout, then a normal access.
    sram_lat   = 3'd2;
    ready_mask = 1'b1;
    access(PORT_I, 1'b0, 4'h0, 12'h020, 32'h0, lat, rd, er, cl);
    ready_mask = 1'b0;
    check("tmo_lat", lat, 16);
    check("tmo_err", er, 1);
    check("tmo_csn_cycles", cl, 15);
    access(PORT_I, 1'b0, 4'h0, 12'h020, 32'h0, lat, rd, er, cl);
    check("post_tmo_lat", lat, 3);
    check("post_tmo_err", er, 0);
    check("post_tmo_data", rd, 32'hFFFFABCD);

    // Reset during a BUSY data read; reissue together with a fetch.
    sram_lat = 3'd3;
    n0 = ack_log.size();
    @(posedge clk); #1;
    base = cyc;
    core.D_REQ = 1'b1; core.D_WE = 1'b0; core.D_BE = 4'h0; core.D_ADDR = 12'h020;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    core.I_REQ = 1'b1; core.I_ADDR = 12'h010;
    @(negedge clk);
    check("mid_rst_csn", mem.M_CSN, 1);
    check("mid_rst_no_dack", core.D_ACK, 0);
    for (int i = 0; i < 60 && ack_log.size() < n0 + 2; i++) begin
      @(posedge clk); #1;
      for (int k = n0; k < ack_log.size(); k++) begin
        if (ack_log[k].port == PORT_I) core.I_REQ = 1'b0;
        else                           core.D_REQ = 1'b0;
      end
    end
    core.I_REQ = 1'b0; core.D_REQ = 1'b0;
    check("mid_rst_count", ack_log.size(), n0 + 2);
    if (ack_log.size() >= n0 + 2) begin
      check("mid_rst_first_port", ack_log[n0].port, PORT_I);
      check("mid_rst_first_cyc",  ack_log[n0].cyc - base, 7);
      check("mid_rst_first_data", ack_log[n0].data, 32'hDEADBEEF);
      check("mid_rst_second_port", ack_log[n0+1].port, PORT_D);
      check("mid_rst_second_cyc",  ack_log[n0+1].cyc - base, 12);
      check("mid_rst_second_data", ack_log[n0+1].data, 32'hFFFFABCD);
      check("mid_rst_second_err",  ack_log[n0+1].err, 0);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
